// File: rtl/isa_pkg.sv
// Shared widths, opcode field position and fetch FSM encoding for the fetch unit.
package isa_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned INSTR_W    = 20;
  localparam int unsigned OPCODE_MSB = 19;
  localparam int unsigned OPCODE_LSB = 15;

  localparam logic [4:0] HALT_OPCODE = 5'b11111;

  // Fetch FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with reset / load / hold / increment selection and range checks.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_load           load i_load_pc (takes priority over i_inc)
//   i_load_pc        load target
//   i_inc            advance PC by one
//   o_pc_q           current PC
//   o_pc_at_last     PC is the last legal word (MEM_DEPTH-1)
//   o_target_oob     i_load_pc lies outside 0..MEM_DEPTH-1
module fetch_pc_reg
  import isa_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc_q,
  output logic              o_pc_at_last,
  output logic              o_target_oob
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_load_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc_q       = r_pc;
  assign o_pc_at_last = (r_pc == ADDR_W'(MEM_DEPTH - 1));
  assign o_target_oob = (32'(i_load_pc) >= MEM_DEPTH);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and
// registers the fetched word for decode. Supports stall, redirect, HALT opcode and
// out-of-range fault (sticky, stops fetching).
// Ports:
//   i_clk, i_reset             clock and synchronous active-high reset
//   i_start                    leave IDLE and begin fetching
//   i_stall                    hold PC and IF register
//   i_redirect, i_redirect_pc  branch/jump target load, flushes IF register
//   o_address, o_memo_read     instruction memory request (from state/PC only)
//   i_instruction              instruction memory read data
//   o_instr_out, o_instr_pc    registered instruction and its PC
//   o_instr_valid              o_instr_out is live
//   o_fetch_count              instructions delivered since reset (wraps)
//   o_halted, o_fault          HALT state indicator, sticky range fault
module instruction_fetch_unit
  import isa_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH = 128,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic [ADDR_W-1:0]  o_address,
  output logic               o_memo_read,
  input  logic [INSTR_W-1:0] i_instruction,
  output logic [INSTR_W-1:0] o_instr_out,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_instr_valid,
  output logic [15:0]        o_fetch_count,
  output logic               o_halted,
  output logic               o_fault
);

  logic [1:0]         r_state;
  logic [INSTR_W-1:0] r_instr_out;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic               r_instr_valid;
  logic [15:0]        r_fetch_count;
  logic               r_fault;

  logic [ADDR_W-1:0]  w_pc_q;
  logic               w_pc_at_last;
  logic               w_target_oob;
  logic               w_fetching;
  logic               w_halt_op;
  logic               w_advance;
  logic               w_pc_load;
  logic               w_pc_inc;

  assign w_fetching = (r_state == ST_FETCH);
  assign w_halt_op  = (i_instruction[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
  assign w_advance  = w_fetching && !i_redirect && !i_stall;
  // An out-of-range redirect faults and leaves the PC where it was.
  assign w_pc_load  = w_fetching && i_redirect && !w_target_oob;
  // The PC freezes on the word that stops fetching (HALT opcode or last legal word).
  assign w_pc_inc   = w_advance && !w_halt_op && !w_pc_at_last;

  fetch_pc_reg #(
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load       (w_pc_load),
    .i_load_pc    (i_redirect_pc),
    .i_inc        (w_pc_inc),
    .o_pc_q       (w_pc_q),
    .o_pc_at_last (w_pc_at_last),
    .o_target_oob (w_target_oob)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_fetch_count <= '0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (i_redirect) begin
            r_instr_valid <= 1'b0;
            if (w_target_oob) begin
              r_fault <= 1'b1;
              r_state <= ST_HALT;
            end
          end else if (!i_stall) begin
            r_instr_out   <= i_instruction;
            r_instr_pc    <= w_pc_q;
            r_instr_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 16'd1;
            if (w_halt_op) begin
              r_state <= ST_HALT;
            end else if (w_pc_at_last) begin
              r_fault <= 1'b1;
              r_state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_address     = w_pc_q;
  assign o_memo_read   = w_fetching;
  assign o_instr_out   = r_instr_out;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_count = r_fetch_count;
  assign o_halted      = (r_state == ST_HALT);
  assign o_fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic        i_stall;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic [15:0] o_address;
  logic        o_memo_read;
  logic [19:0] i_instruction;
  logic [19:0] o_instr_out;
  logic [15:0] o_instr_pc;
  logic        o_instr_valid;
  logic [15:0] o_fetch_count;
  logic        o_halted;
  logic        o_fault;

  logic [19:0] mem [0:127];

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_address     (o_address),
    .o_memo_read   (o_memo_read),
    .i_instruction (i_instruction),
    .o_instr_out   (o_instr_out),
    .o_instr_pc    (o_instr_pc),
    .o_instr_valid (o_instr_valid),
    .o_fetch_count (o_fetch_count),
    .o_halted      (o_halted),
    .o_fault       (o_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational instruction memory
  assign i_instruction = (o_address < 16'd128) ? mem[o_address[6:0]] : 20'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: mode 0 idle, 1 fetching, 2 halted.
  int          m_mode;
  logic [15:0] m_pc;
  logic [19:0] m_out;
  logic [15:0] m_ipc;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic        m_fault;
  logic        m_live = 1'b0;

  always @(posedge clk) begin
    if (i_reset) begin
      m_live  <= 1'b1;
      m_mode  <= 0;
      m_pc    <= 16'd0;
      m_out   <= 20'd0;
      m_ipc   <= 16'd0;
      m_valid <= 1'b0;
      m_cnt   <= 16'd0;
      m_fault <= 1'b0;
    end else if (m_mode == 0) begin
      if (i_start) m_mode <= 1;
    end else if (m_mode == 1) begin
      if (i_redirect) begin
        m_valid <= 1'b0;
        if (i_redirect_pc >= 16'd128) begin
          m_fault <= 1'b1;
          m_mode  <= 2;
        end else begin
          m_pc <= i_redirect_pc;
        end
      end else if (!i_stall) begin
        m_out   <= mem[m_pc[6:0]];
        m_ipc   <= m_pc;
        m_valid <= 1'b1;
        m_cnt   <= m_cnt + 16'd1;
        if (mem[m_pc[6:0]][19:15] == 5'h1f) begin
          m_mode <= 2;
        end else if (m_pc == 16'd127) begin
          m_fault <= 1'b1;
          m_mode  <= 2;
        end else begin
          m_pc <= m_pc + 16'd1;
        end
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("address", 32'(o_address), 32'(m_pc));
      check("memo_read", 32'(o_memo_read), 32'(m_mode == 1));
      check("instr_out", 32'(o_instr_out), 32'(m_out));
      check("instr_pc", 32'(o_instr_pc), 32'(m_ipc));
      check("instr_valid", 32'(o_instr_valid), 32'(m_valid));
      check("fetch_count", 32'(o_fetch_count), 32'(m_cnt));
      check("halted", 32'(o_halted), 32'(m_mode == 2));
      check("fault", 32'(o_fault), 32'(m_fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset_start();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    i_reset       = 1'b1;
    i_start       = 1'b0;
    i_stall       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 16'd0;
    for (int i = 0; i < 128; i++) mem[i] = {5'(i % 30), 15'(i)};

    // 1: reset values, then sequential fetch of 0..3
    tick();
    tick();
    i_reset = 1'b0;
    sample();
    check("rst_valid", 32'(o_instr_valid), 32'd0);
    check("rst_memo_read", 32'(o_memo_read), 32'd0);
    check("rst_count", 32'(o_fetch_count), 32'd0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      check("t1_instr_pc", 32'(o_instr_pc), 32'(k));
      check("t1_valid", 32'(o_instr_valid), 32'd1);
    end
    check("t1_count", 32'(o_fetch_count), 32'd4);

    // 2: stall three cycles at pc=2
    do_reset_start();
    tick();
    tick();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      sample();
      check("t2_address", 32'(o_address), 32'd2);
      check("t2_instr_pc", 32'(o_instr_pc), 32'd1);
      check("t2_count", 32'(o_fetch_count), 32'd2);
    end
    i_stall = 1'b0;
    tick();
    sample();
    check("t2_resume_pc", 32'(o_instr_pc), 32'd2);
    tick();
    sample();
    check("t2_resume_pc2", 32'(o_instr_pc), 32'd3);

    // 3: redirect wins over stall
    i_redirect    = 1'b1;
    i_redirect_pc = 16'd40;
    i_stall       = 1'b1;
    tick();
    sample();
    check("t3_bubble", 32'(o_instr_valid), 32'd0);
    check("t3_address", 32'(o_address), 32'd40);
    check("t3_count", 32'(o_fetch_count), 32'd4);
    i_redirect = 1'b0;
    i_stall    = 1'b0;
    tick();
    sample();
    check("t3_instr_pc", 32'(o_instr_pc), 32'd40);
    check("t3_instr_out", 32'(o_instr_out), 32'h50028);
    check("t3_count2", 32'(o_fetch_count), 32'd5);

    // 4: HALT opcode at address 5
    mem[5] = {5'b11111, 15'h0005};
    do_reset_start();
    for (int k = 0; k < 6; k++) tick();
    sample();
    check("t4_instr_pc", 32'(o_instr_pc), 32'd5);
    check("t4_valid", 32'(o_instr_valid), 32'd1);
    check("t4_halted", 32'(o_halted), 32'd1);
    check("t4_memo_read", 32'(o_memo_read), 32'd0);
    tick();
    sample();
    check("t4_valid_drop", 32'(o_instr_valid), 32'd0);
    check("t4_fault", 32'(o_fault), 32'd0);
    check("t4_count", 32'(o_fetch_count), 32'd6);
    mem[5] = {5'd5, 15'd5};

    // 5: run off the end of memory
    do_reset_start();
    i_redirect    = 1'b1;
    i_redirect_pc = 16'd120;
    tick();
    i_redirect = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    sample();
    check("t5_instr_pc", 32'(o_instr_pc), 32'd127);
    check("t5_fault", 32'(o_fault), 32'd1);
    check("t5_halted", 32'(o_halted), 32'd1);
    check("t5_address", 32'(o_address), 32'd127);
    tick();
    sample();
    check("t5_address_hold", 32'(o_address), 32'd127);
    check("t5_valid_drop", 32'(o_instr_valid), 32'd0);

    // 6: out-of-range redirect, then reset from HALT
    do_reset_start();
    i_redirect    = 1'b1;
    i_redirect_pc = 16'd200;
    tick();
    i_redirect = 1'b0;
    sample();
    check("t6_fault", 32'(o_fault), 32'd1);
    check("t6_halted", 32'(o_halted), 32'd1);
    check("t6_address", 32'(o_address), 32'd0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    sample();
    check("t6_rst_fault", 32'(o_fault), 32'd0);
    check("t6_rst_halted", 32'(o_halted), 32'd0);
    check("t6_rst_memo", 32'(o_memo_read), 32'd0);
    check("t6_rst_out", 32'(o_instr_out), 32'd0);
    check("t6_rst_count", 32'(o_fetch_count), 32'd0);

    // Randomized traffic checked against the reference every cycle
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 15) == 0) mem[i] = {5'h1f, 15'($urandom)};
      else                            mem[i] = {5'($urandom_range(0, 30)), 15'($urandom)};
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_reset    = ($urandom_range(0, 49) == 0);
      i_start    = ($urandom_range(0, 3) == 0);
      i_stall    = ($urandom_range(0, 4) == 0);
      i_redirect = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) i_redirect_pc = 16'($urandom_range(128, 65535));
      else                           i_redirect_pc = 16'($urandom_range(0, 127));
      tick();
    end
    i_reset    = 1'b0;
    i_start    = 1'b0;
    i_stall    = 1'b0;
    i_redirect = 1'b0;
    tick();
    sample();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
